// File: rtl/alut_mem_arb16_pkg.sv
// Shared types and defaults for the ALUT table RAM arbiter.
package alut_pkg16;

  localparam int unsigned DW16 = 83;
  localparam int unsigned AW16 = 8;

  typedef enum logic [1:0] {
    REQ_CHK,
    REQ_CPU,
    REQ_AGE
  } req_id_e;

  typedef struct packed {
    logic [AW16-1:0] addr;
    logic            wr;
    logic [DW16-1:0] wdata;
  } alut_req_t;

endpackage

// File: rtl/alut_mem_arb16_rr_arb.sv
// Two-way CPU/ager round-robin for RAM port B with per-requester starvation counters.
module alut_rr_arb16 #(
  parameter int unsigned MAX_WAIT16 = 15
) (
  input  logic pclk16,
  input  logic rst16,
  input  logic req_cpu16,
  input  logic req_age16,
  input  logic gnt_b16,
  output logic cand_vld16,
  output logic cand_age16,
  output logic cand_forced16
);
  import alut_pkg16::*;

  localparam int unsigned CW = $clog2(MAX_WAIT16 + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_WAIT16);

  logic [CW-1:0] cnt_cpu;
  logic [CW-1:0] cnt_age;
  req_id_e       ptr;
  logic          cpu_sat;
  logic          age_sat;

  // Saturated counters override the pointer; the ager wins when both are starved.
  always_comb begin
    cpu_sat    = req_cpu16 && (cnt_cpu == MAXC);
    age_sat    = req_age16 && (cnt_age == MAXC);
    cand_vld16 = req_cpu16 || req_age16;
    if (age_sat)
      cand_age16 = 1'b1;
    else if (cpu_sat)
      cand_age16 = 1'b0;
    else if (req_cpu16 && req_age16)
      cand_age16 = (ptr == REQ_AGE);
    else
      cand_age16 = req_age16;
    cand_forced16 = cand_age16 ? age_sat : cpu_sat;
  end

  always_ff @(posedge pclk16) begin
    if (rst16) begin
      ptr     <= REQ_CPU;
      cnt_cpu <= '0;
      cnt_age <= '0;
    end else begin
      if (gnt_b16)
        ptr <= cand_age16 ? REQ_CPU : REQ_AGE;

      if (!req_cpu16 || (gnt_b16 && !cand_age16))
        cnt_cpu <= '0;
      else if (cnt_cpu != MAXC)
        cnt_cpu <= cnt_cpu + 1'b1;

      if (!req_age16 || (gnt_b16 && cand_age16))
        cnt_age <= '0;
      else if (cnt_age != MAXC)
        cnt_age <= cnt_age + 1'b1;
    end
  end

endmodule

// File: rtl/alut_mem_arb16.sv
// ALUT table RAM arbiter: port A for the address checker, port B shared by CPU and ager.
module alut_mem_arb16 #(
  parameter int unsigned DW16       = alut_pkg16::DW16,
  parameter int unsigned AW16       = alut_pkg16::AW16,
  parameter int unsigned MAX_WAIT16 = 15
) (
  input  logic            pclk16,
  input  logic            rst16,
  input  logic            chk_req16,
  input  logic [AW16-1:0] chk_addr16,
  input  logic            chk_wr16,
  input  logic [DW16-1:0] chk_wdata16,
  output logic            chk_gnt16,
  output logic            chk_rvalid16,
  output logic [DW16-1:0] chk_rdata16,
  input  logic            cpu_req16,
  input  logic [AW16-1:0] cpu_addr16,
  input  logic            cpu_wr16,
  input  logic [DW16-1:0] cpu_wdata16,
  output logic            cpu_gnt16,
  output logic            cpu_rvalid16,
  output logic [DW16-1:0] cpu_rdata16,
  input  logic            age_req16,
  input  logic [AW16-1:0] age_addr16,
  input  logic            age_wr16,
  input  logic [DW16-1:0] age_wdata16,
  output logic            age_gnt16,
  output logic            age_rvalid16,
  output logic [DW16-1:0] age_rdata16,
  output logic [AW16-1:0] mem_addr_add16,
  output logic            mem_write_add16,
  output logic [DW16-1:0] mem_write_data_add16,
  input  logic [DW16-1:0] mem_read_data_add16,
  output logic [AW16-1:0] mem_addr_age16,
  output logic            mem_write_age16,
  output logic [DW16-1:0] mem_write_data_age16,
  input  logic [DW16-1:0] mem_read_data_age16
);
  import alut_pkg16::*;

  logic            cand_vld;
  logic            cand_age;
  logic            cand_forced;
  req_id_e         b_id;
  logic [AW16-1:0] b_addr;
  logic            b_wr;
  logic [DW16-1:0] b_wdata;
  logic            coll;
  logic            chk_go;
  logic            b_go;
  logic            chk_rv, cpu_rv, age_rv;
  logic [DW16-1:0] chk_hold, cpu_hold, age_hold;

  alut_rr_arb16 #(.MAX_WAIT16(MAX_WAIT16)) u_rr_b (
    .pclk16       (pclk16),
    .rst16        (rst16),
    .req_cpu16    (cpu_req16),
    .req_age16    (age_req16),
    .gnt_b16      (b_go),
    .cand_vld16   (cand_vld),
    .cand_age16   (cand_age),
    .cand_forced16(cand_forced)
  );

  // A same-address pair involving a write goes to the checker unless the B candidate is starved.
  always_comb begin
    b_id    = cand_age ? REQ_AGE : REQ_CPU;
    b_addr  = (b_id == REQ_AGE) ? age_addr16  : cpu_addr16;
    b_wr    = (b_id == REQ_AGE) ? age_wr16    : cpu_wr16;
    b_wdata = (b_id == REQ_AGE) ? age_wdata16 : cpu_wdata16;
    coll    = chk_req16 && cand_vld && (chk_addr16 == b_addr) && (chk_wr16 || b_wr);
    chk_go  = !rst16 && chk_req16 && !(coll && cand_forced);
    b_go    = !rst16 && cand_vld && !(coll && !cand_forced);
  end

  assign chk_gnt16 = chk_go;
  assign cpu_gnt16 = b_go && (b_id == REQ_CPU);
  assign age_gnt16 = b_go && (b_id == REQ_AGE);

  assign mem_addr_add16       = chk_go ? chk_addr16 : '0;
  assign mem_write_add16      = chk_go && chk_wr16;
  assign mem_write_data_add16 = (chk_go && chk_wr16) ? chk_wdata16 : '0;
  assign mem_addr_age16       = b_go ? b_addr : '0;
  assign mem_write_age16      = b_go && b_wr;
  assign mem_write_data_age16 = (b_go && b_wr) ? b_wdata : '0;

  always_ff @(posedge pclk16) begin
    if (rst16) begin
      chk_rv   <= 1'b0;
      cpu_rv   <= 1'b0;
      age_rv   <= 1'b0;
      chk_hold <= '0;
      cpu_hold <= '0;
      age_hold <= '0;
    end else begin
      chk_rv <= chk_gnt16 && !chk_wr16;
      cpu_rv <= cpu_gnt16 && !cpu_wr16;
      age_rv <= age_gnt16 && !age_wr16;
      if (chk_rv) chk_hold <= mem_read_data_add16;
      if (cpu_rv) cpu_hold <= mem_read_data_age16;
      if (age_rv) age_hold <= mem_read_data_age16;
    end
  end

  // The live RAM word is passed through on the valid cycle and latched for later cycles.
  assign chk_rvalid16 = chk_rv && !rst16;
  assign cpu_rvalid16 = cpu_rv && !rst16;
  assign age_rvalid16 = age_rv && !rst16;
  assign chk_rdata16  = chk_rvalid16 ? mem_read_data_add16 : chk_hold;
  assign cpu_rdata16  = cpu_rvalid16 ? mem_read_data_age16 : cpu_hold;
  assign age_rdata16  = age_rvalid16 ? mem_read_data_age16 : age_hold;

endmodule
